hyper_lsab_dram_stage: RTL
==========================

// Module: hyper_lsab_dram_stage
// PURPOSE
//  Four-section staging buffer (LSAB) feeding the DRAM block mover.
//  Fabric side pushes words into a selected section; the mover pops them via
//  LSAB_READ/LSAB_SECTION and watches the per-section EMPTY flags.
//  Sits directly upstream of the to-DRAM block mover; one instance per channel.
// PARAMETERS
//  DATA_W    32  word width, fabric and DRAM side
//  SECT_AW    5  log2 words per section (32 words; covers 24-word blocks)
// PORTS
//  CLK            in   1       clock
//  RST            in   1       reset, synchronous, active-low
//  WR_EN          in   1       push WR_DATA into section WR_SECTION this edge
//  WR_SECTION     in   2       target section of push
//  WR_DATA        in   DATA_W  push data
//  FLUSH          in   4       per-section pointer clear, bit n = section n
//  LSAB_READ      in   1       pop one word from section LSAB_SECTION
//  LSAB_SECTION   in   2       section popped
//  RD_DATA        out  DATA_W  popped word, registered
//  RD_VALID       out  1       RD_DATA holds a word popped on the previous edge
//  LSAB_0_EMPTY   out  1       section 0 empty (likewise _1, _2, _3)
//  LSAB_0_FULL    out  1       section 0 full (likewise _1, _2, _3)
//  ERR_OVF        out  1       sticky: a push hit a full section
//  ERR_UDF        out  1       sticky: a pop hit an empty section
//  ERR_CLR        in   1       clears both sticky flags
// BEHAVIOUR
//  Reset (RST low at edge): all pointers 0, every EMPTY=1, every FULL=0,
//   RD_DATA=0, RD_VALID=0, ERR_OVF=ERR_UDF=0. Memory contents not cleared.
//   Reset mid-operation discards all buffered data; no partial pop completes.
//  Per section: wr_ptr, rd_ptr, each SECT_AW+1 bits (MSB = wrap bit).
//   EMPTY = (wr_ptr == rd_ptr); FULL = low bits equal and wrap bits differ.
//   Flags are registered, updated on the same edge as the pointers.
//  Storage: one 1W1R array of 4*2^SECT_AW words, addr = {section, ptr[AW-1:0]}.
//  Push: WR_EN and section not FULL (pre-edge) -> write, wr_ptr+1.
//   If FULL -> word dropped, pointer unchanged, ERR_OVF<=1. A same-cycle pop
//   of that section does not rescue the push.
//  Pop: LSAB_READ and section not EMPTY (pre-edge) -> RD_DATA <= word at
//   rd_ptr, rd_ptr+1, RD_VALID<=1 next cycle (latency 1).
//   If EMPTY -> RD_VALID<=0, RD_DATA holds, ERR_UDF<=1. No write-to-read
//   bypass: a push into an empty section becomes poppable one cycle later.
//  Same address read/write cannot occur (only when full or empty, both blocked).
//  Push and pop to the same or different sections in one cycle: both proceed.
//  Pointer arithmetic wraps modulo 2^(SECT_AW+1) naturally; no saturation.
//  FLUSH[n]: rd_ptr=wr_ptr=0 for section n; overrides push/pop to n that
//   cycle (neither counted as error); EMPTY_n=1, FULL_n=0 next cycle.
//  ERR_CLR: clears sticky flags; a new error in the same cycle wins (set).
//  No state machine beyond pointers; RD_VALID drops when LSAB_READ drops.
// STRUCTURE
//  Shared package: DATA_W, SECT_AW, section count (4), section encoding 2'b00..11.
//  Sub-module hyper_lsab_sect_ptr: one section's pointers, flags, push/pop
//   acceptance, flush; instantiated 4x. Top holds array, read mux, errors.
// TESTING
//  Reset then idle -> all EMPTY=1, FULL=0, RD_VALID=0, errors 0.
//  Push 0xA0..0xB7 (24 words) to section 2, pop 24 -> RD_DATA 0xA0..0xB7 in
//   order, one cycle after each LSAB_READ; EMPTY_2 rises after last pop.
//  Push 33 words to section 1 -> FULL_1 after 32nd, 33rd dropped, ERR_OVF=1;
//   ERR_CLR -> ERR_OVF=0.
//  Pop empty section 3 -> RD_VALID=0, RD_DATA unchanged, ERR_UDF=1.
//  Fill/drain section 0 three times (96 words, wrap) with concurrent pushes
//   to section 1 -> data intact, no cross-section corruption.
//  Push 5 to section 0, FLUSH=4'b0001 same cycle as push+pop -> EMPTY_0=1, no
//   error; RST low mid-stream -> all flags return to reset values.

Source files
------------

// File: rtl/hyper_lsab_dram_stage_pkg.sv
// Shared constants and helpers for the LSAB DRAM staging buffer.
// Word width, section geometry, section encoding, array address helper.
package hyper_lsab_dram_stage_pkg;
   localparam int DATA_W = 32;
   localparam int SECT_AW = 5;
   localparam int N_SECT = 4;
   localparam int SECT_D = 1 << SECT_AW;
   localparam int MEM_D = N_SECT * SECT_D;

   typedef enum logic [1:0] {
      SECT_0 = 2'b00,
      SECT_1 = 2'b01,
      SECT_2 = 2'b10,
      SECT_3 = 2'b11
   } sect_e;

   function automatic logic [SECT_AW+1:0] mem_addr(
      input logic [1:0] sect,
      input logic [SECT_AW-1:0] ptr
   );
      return {sect, ptr};
   endfunction
endpackage

// File: rtl/hyper_lsab_sect_ptr.sv
// One LSAB section: wrap-bit pointers, registered EMPTY/FULL, flush.
// Ports: push/pop/flush requests in; addresses, flags, accept/error out.
module hyper_lsab_sect_ptr
   import hyper_lsab_dram_stage_pkg::*;
(
   input  logic               CLK,
   input  logic               RST,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   output logic [SECT_AW-1:0] wr_addr,
   output logic [SECT_AW-1:0] rd_addr,
   output logic               empty,
   output logic               full,
   output logic               push_ok,
   output logic               pop_ok,
   output logic               ovf,
   output logic               udf
);
   logic [SECT_AW:0] wr_ptr;
   logic [SECT_AW:0] rd_ptr;
   logic [SECT_AW:0] wr_nxt;
   logic [SECT_AW:0] rd_nxt;

   // Flush suppresses both the transfer and its error report.
   assign push_ok = push & ~full & ~flush;
   assign pop_ok  = pop & ~empty & ~flush;
   assign ovf     = push & full & ~flush;
   assign udf     = pop & empty & ~flush;

   assign wr_addr = wr_ptr[SECT_AW-1:0];
   assign rd_addr = rd_ptr[SECT_AW-1:0];

   always_comb begin
      wr_nxt = wr_ptr + {{SECT_AW{1'b0}}, push_ok};
      rd_nxt = rd_ptr + {{SECT_AW{1'b0}}, pop_ok};
   end

   always_ff @(posedge CLK) begin
      if (!RST || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         empty  <= (wr_nxt == rd_nxt);
         full   <= (wr_nxt[SECT_AW-1:0] == rd_nxt[SECT_AW-1:0])
                && (wr_nxt[SECT_AW] != rd_nxt[SECT_AW]);
      end
   end
endmodule

// File: rtl/hyper_lsab_dram_stage.sv
// Four-section staging buffer feeding the DRAM block mover.
// Ports: fabric push (WR_*), mover pop (LSAB_*), RD_DATA/RD_VALID, flags, errors.
module hyper_lsab_dram_stage
   import hyper_lsab_dram_stage_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              WR_EN,
   input  logic [1:0]        WR_SECTION,
   input  logic [DATA_W-1:0] WR_DATA,
   input  logic [3:0]        FLUSH,
   input  logic              LSAB_READ,
   input  logic [1:0]        LSAB_SECTION,
   output logic [DATA_W-1:0] RD_DATA,
   output logic              RD_VALID,
   output logic              LSAB_0_EMPTY,
   output logic              LSAB_1_EMPTY,
   output logic              LSAB_2_EMPTY,
   output logic              LSAB_3_EMPTY,
   output logic              LSAB_0_FULL,
   output logic              LSAB_1_FULL,
   output logic              LSAB_2_FULL,
   output logic              LSAB_3_FULL,
   output logic              ERR_OVF,
   output logic              ERR_UDF,
   input  logic              ERR_CLR
);
   logic [N_SECT-1:0]  push_v;
   logic [N_SECT-1:0]  pop_v;
   logic [N_SECT-1:0]  push_ok;
   logic [N_SECT-1:0]  pop_ok;
   logic [N_SECT-1:0]  ovf;
   logic [N_SECT-1:0]  udf;
   logic [N_SECT-1:0]  empty;
   logic [N_SECT-1:0]  full;
   logic [SECT_AW-1:0] wr_addr [N_SECT];
   logic [SECT_AW-1:0] rd_addr [N_SECT];
   logic [DATA_W-1:0]  mem [MEM_D];

   for (genvar i = 0; i < N_SECT; i++) begin : g_sect
      assign push_v[i] = WR_EN && (WR_SECTION == 2'(i));
      assign pop_v[i]  = LSAB_READ && (LSAB_SECTION == 2'(i));

      hyper_lsab_sect_ptr u_ptr (
         .CLK     (CLK),
         .RST     (RST),
         .push    (push_v[i]),
         .pop     (pop_v[i]),
         .flush   (FLUSH[i]),
         .wr_addr (wr_addr[i]),
         .rd_addr (rd_addr[i]),
         .empty   (empty[i]),
         .full    (full[i]),
         .push_ok (push_ok[i]),
         .pop_ok  (pop_ok[i]),
         .ovf     (ovf[i]),
         .udf     (udf[i])
      );
   end

   // Storage is never reset; pointers alone define valid contents.
   always_ff @(posedge CLK) begin
      if (RST && |push_ok)
         mem[mem_addr(WR_SECTION, wr_addr[WR_SECTION])] <= WR_DATA;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         RD_DATA  <= '0;
         RD_VALID <= 1'b0;
         ERR_OVF  <= 1'b0;
         ERR_UDF  <= 1'b0;
      end else begin
         RD_VALID <= |pop_ok;
         if (|pop_ok)
            RD_DATA <= mem[mem_addr(LSAB_SECTION, rd_addr[LSAB_SECTION])];
         // A fresh error in the clear cycle still sets the flag.
         ERR_OVF <= |ovf | (ERR_OVF & ~ERR_CLR);
         ERR_UDF <= |udf | (ERR_UDF & ~ERR_CLR);
      end
   end

   assign LSAB_0_EMPTY = empty[0];
   assign LSAB_1_EMPTY = empty[1];
   assign LSAB_2_EMPTY = empty[2];
   assign LSAB_3_EMPTY = empty[3];
   assign LSAB_0_FULL  = full[0];
   assign LSAB_1_FULL  = full[1];
   assign LSAB_2_FULL  = full[2];
   assign LSAB_3_FULL  = full[3];
endmodule
